// File: rtl/btn_pkg.sv
// Shared types and default configuration for the pushbutton debouncer.
package btn_pkg;

    typedef enum logic [1:0] {
        S_LOW,
        S_WAIT_HIGH,
        S_HIGH,
        S_WAIT_LOW
    } btn_state_t;

    localparam int DEFAULT_SYNC_STAGES       = 2;
    localparam int DEFAULT_DEBOUNCE_CYCLES   = 1_000_000;
    localparam int DEFAULT_LONG_PRESS_CYCLES = 100_000_000;

endpackage

// File: rtl/btn_sync.sv
// Multi-flop synchroniser bringing the raw button into the local clock domain.
module btn_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    genvar gi;
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
        if (gi == 0) begin : g_first
            assign sync_d[gi] = d_i;
        end else begin : g_next
            assign sync_d[gi] = sync_q[gi-1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/btn_debounce.sv
// Pushbutton conditioner: synchroniser, stability-counter debounce FSM, edge pulses.
// Optional long-hold pulse enabled by defining BTN_DEBOUNCE_LONG_PRESS_EN.
module btn_debounce
    import btn_pkg::*;
#(
    parameter int SYNC_STAGES       = DEFAULT_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
    parameter int LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES
) (
    input  logic clk100mhz,
    input  logic rst_n,
    input  logic btn,
    output logic btn_level,
    output logic btn_rise,
    output logic btn_fall,
    output logic long_press
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic       sync_btn;
    btn_state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic       level_q, level_d;
    logic       rise_q, rise_d;
    logic       fall_q, fall_d;

    btn_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_i (clk100mhz),
        .rst_ni(rst_n),
        .d_i   (btn),
        .q_o   (sync_btn)
    );

    // The counter tracks how many consecutive cycles the candidate level has held.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            S_LOW: begin
                if (sync_btn) begin
                    state_d = S_WAIT_HIGH;
                    cnt_d   = CNT_ONE;
                end
            end
            S_WAIT_HIGH: begin
                if (!sync_btn) begin
                    state_d = S_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_HIGH;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    rise_d  = 1'b1;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_HIGH: begin
                if (!sync_btn) begin
                    state_d = S_WAIT_LOW;
                    cnt_d   = CNT_ONE;
                end
            end
            S_WAIT_LOW: begin
                if (sync_btn) begin
                    state_d = S_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_LOW;
                    cnt_d   = '0;
                    level_d = 1'b0;
                    fall_d  = 1'b1;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = S_LOW;
                cnt_d   = '0;
                level_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk100mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_LOW;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign btn_level = level_q;
    assign btn_rise  = rise_q;
    assign btn_fall  = fall_q;

`ifdef BTN_DEBOUNCE_LONG_PRESS_EN
    // The hold count only needs to reach LONG_PRESS_CYCLES-1 before the pulse fires.
    localparam int               HOLD_W    = $clog2(LONG_PRESS_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              fired_q, fired_d;
    logic              long_q, long_d;

    always_comb begin
        hold_d  = hold_q;
        fired_d = fired_q;
        long_d  = 1'b0;
        if (state_q != S_HIGH) begin
            hold_d  = '0;
            fired_d = 1'b0;
        end else if (!fired_q) begin
            if (hold_q == HOLD_LAST) begin
                long_d  = 1'b1;
                fired_d = 1'b1;
            end else begin
                hold_d = hold_q + HOLD_ONE;
            end
        end
    end

    always_ff @(posedge clk100mhz or negedge rst_n) begin
        if (!rst_n) begin
            hold_q  <= '0;
            fired_q <= 1'b0;
            long_q  <= 1'b0;
        end else begin
            hold_q  <= hold_d;
            fired_q <= fired_d;
            long_q  <= long_d;
        end
    end

    assign long_press = long_q;
`else
    localparam int unused_long_press_cycles = LONG_PRESS_CYCLES;
    assign long_press = 1'b0;
`endif

endmodule

// File: tb/tb_btn_debounce.sv
// Scoreboard bench for btn_debounce: expected pulse events are queued at stimulus time
// and matched against pulses recorded from the DUT.
module tb_btn_debounce;

    localparam int DEB  = 8;
    localparam int SYNC = 2;
    localparam int LONG = 32;
    // Input driven on the falling edge that follows edge c is sampled at edge c+1,
    // so the accepted level appears at edge c+SYNC+DEB.
    localparam int LAT  = SYNC + DEB;

    localparam logic [1:0] EV_RISE = 2'd0;
    localparam logic [1:0] EV_FALL = 2'd1;
    localparam logic [1:0] EV_LONG = 2'd2;

    typedef struct packed {
        logic [1:0]  kind;
        logic [29:0] cyc;
    } ev_t;

    logic clk100mhz = 1'b0;
    logic rst_n     = 1'b0;
    logic btn       = 1'b0;
    logic btn_level;
    logic btn_rise;
    logic btn_fall;
    logic long_press;

    int  cyc     = 0;
    int  vec_cnt = 0;
    int  err_cnt = 0;
    ev_t exp_q[$];
    ev_t obs_q[$];

    btn_debounce #(
        .SYNC_STAGES      (SYNC),
        .DEBOUNCE_CYCLES  (DEB),
        .LONG_PRESS_CYCLES(LONG)
    ) dut (
        .clk100mhz (clk100mhz),
        .rst_n     (rst_n),
        .btn       (btn),
        .btn_level (btn_level),
        .btn_rise  (btn_rise),
        .btn_fall  (btn_fall),
        .long_press(long_press)
    );

    always #5 clk100mhz = ~clk100mhz;

    always @(posedge clk100mhz) cyc <= cyc + 1;

    function automatic ev_t mk_ev(input logic [1:0] kind, input int c);
        ev_t e;
        e.kind = kind;
        e.cyc  = 30'(c);
        return e;
    endfunction

    function automatic string kname(input logic [1:0] kind);
        case (kind)
            EV_RISE: return "rise";
            EV_FALL: return "fall";
            EV_LONG: return "long";
            default: return "none";
        endcase
    endfunction

    // Monitor: record every output pulse with the edge index that produced it.
    always @(posedge clk100mhz) begin
        #2;
        if (rst_n) begin
            if (btn_rise)   obs_q.push_back(mk_ev(EV_RISE, cyc));
            if (btn_fall)   obs_q.push_back(mk_ev(EV_FALL, cyc));
            if (long_press) obs_q.push_back(mk_ev(EV_LONG, cyc));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk100mhz);
    endtask

    task automatic test_reset;
        step(3);
        vec_cnt++;
        if (btn_level !== 1'b0) begin err_cnt++; $display("FAIL reset_level: got %b, expected 0", btn_level); end
        vec_cnt++;
        if (btn_rise !== 1'b0) begin err_cnt++; $display("FAIL reset_rise: got %b, expected 0", btn_rise); end
        vec_cnt++;
        if (btn_fall !== 1'b0) begin err_cnt++; $display("FAIL reset_fall: got %b, expected 0", btn_fall); end
        vec_cnt++;
        if (long_press !== 1'b0) begin err_cnt++; $display("FAIL reset_long: got %b, expected 0", long_press); end
        rst_n = 1'b1;
        step(4);
        vec_cnt++;
        if (btn_level !== 1'b0) begin err_cnt++; $display("FAIL reset_idle_level: got %b, expected 0", btn_level); end
        $display("reset: released at cycle %0d", cyc);
    endtask

    task automatic test_clean_press;
        int  c;
        ev_t e;
        ev_t o;
        c   = cyc;
        btn = 1'b1;
        exp_q.push_back(mk_ev(EV_RISE, c + LAT));
        step(LAT - 1);
        vec_cnt++;
        if (btn_level !== 1'b0) begin err_cnt++; $display("FAIL press_early: got level %b at cycle %0d, expected 0", btn_level, cyc); end
        step(1);
        vec_cnt++;
        if (btn_level !== 1'b1) begin err_cnt++; $display("FAIL press_level: got level %b at cycle %0d, expected 1", btn_level, cyc); end
        step(20 - LAT);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            vec_cnt++;
            if (obs_q.size() == 0) begin
                err_cnt++; $display("FAIL press_event: got none, expected %s@%0d", kname(e.kind), e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin err_cnt++; $display("FAIL press_event: got %s@%0d, expected %s@%0d", kname(o.kind), o.cyc, kname(e.kind), e.cyc); end
            end
        end
        vec_cnt++;
        if (obs_q.size() != 0) begin err_cnt++; $display("FAIL press_extra: got %0d extra events, expected 0", obs_q.size()); obs_q.delete(); end
        $display("clean_press: btn high at cycle %0d, level=%b", c, btn_level);
    endtask

    task automatic test_release;
        int  c;
        ev_t e;
        ev_t o;
        c   = cyc;
        btn = 1'b0;
        exp_q.push_back(mk_ev(EV_FALL, c + LAT));
        step(LAT - 1);
        vec_cnt++;
        if (btn_level !== 1'b1) begin err_cnt++; $display("FAIL release_early: got level %b at cycle %0d, expected 1", btn_level, cyc); end
        step(1);
        vec_cnt++;
        if (btn_level !== 1'b0) begin err_cnt++; $display("FAIL release_level: got level %b at cycle %0d, expected 0", btn_level, cyc); end
        step(12 - LAT);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            vec_cnt++;
            if (obs_q.size() == 0) begin
                err_cnt++; $display("FAIL release_event: got none, expected %s@%0d", kname(e.kind), e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin err_cnt++; $display("FAIL release_event: got %s@%0d, expected %s@%0d", kname(o.kind), o.cyc, kname(e.kind), e.cyc); end
            end
        end
        vec_cnt++;
        if (obs_q.size() != 0) begin err_cnt++; $display("FAIL release_extra: got %0d extra events, expected 0", obs_q.size()); obs_q.delete(); end
        $display("release: btn low at cycle %0d, level=%b", c, btn_level);
    endtask

    task automatic test_bounce_reject;
        for (int i = 0; i < 4; i++) begin
            btn = (i % 2 == 0) ? 1'b1 : 1'b0;
            step(3);
        end
        btn = 1'b0;
        step(15);
        vec_cnt++;
        if (btn_level !== 1'b0) begin err_cnt++; $display("FAIL bounce_level: got %b, expected 0", btn_level); end
        vec_cnt++;
        if (obs_q.size() != 0) begin err_cnt++; $display("FAIL bounce_extra: got %0d events, expected 0", obs_q.size()); obs_q.delete(); end
        $display("bounce_reject: done at cycle %0d, level=%b", cyc, btn_level);
    endtask

    task automatic test_bounce_settle;
        int  c;
        ev_t e;
        ev_t o;
        for (int i = 0; i < 4; i++) begin
            btn = 1'b1;
            step(2);
            btn = 1'b0;
            step(2);
        end
        c   = cyc;
        btn = 1'b1;
        exp_q.push_back(mk_ev(EV_RISE, c + LAT));
        step(16);
        vec_cnt++;
        if (btn_level !== 1'b1) begin err_cnt++; $display("FAIL settle_level: got %b, expected 1", btn_level); end
        c   = cyc;
        btn = 1'b0;
        exp_q.push_back(mk_ev(EV_FALL, c + LAT));
        step(12);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            vec_cnt++;
            if (obs_q.size() == 0) begin
                err_cnt++; $display("FAIL settle_event: got none, expected %s@%0d", kname(e.kind), e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin err_cnt++; $display("FAIL settle_event: got %s@%0d, expected %s@%0d", kname(o.kind), o.cyc, kname(e.kind), e.cyc); end
            end
        end
        vec_cnt++;
        if (obs_q.size() != 0) begin err_cnt++; $display("FAIL settle_extra: got %0d extra events, expected 0", obs_q.size()); obs_q.delete(); end
        $display("bounce_settle: done at cycle %0d, level=%b", cyc, btn_level);
    endtask

    task automatic test_reset_mid;
        int  c;
        ev_t e;
        ev_t o;
        btn = 1'b1;
        step(5);
        #1 rst_n = 1'b0;
        #1;
        vec_cnt++;
        if ({btn_level, btn_rise, btn_fall, long_press} !== 4'b0000) begin
            err_cnt++; $display("FAIL midreset_outputs: got %b, expected 0000", {btn_level, btn_rise, btn_fall, long_press});
        end
        step(2);
        c     = cyc;
        rst_n = 1'b1;
        exp_q.push_back(mk_ev(EV_RISE, c + LAT));
        step(LAT + 4);
        vec_cnt++;
        if (btn_level !== 1'b1) begin err_cnt++; $display("FAIL midreset_level: got %b, expected 1", btn_level); end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            vec_cnt++;
            if (obs_q.size() == 0) begin
                err_cnt++; $display("FAIL midreset_event: got none, expected %s@%0d", kname(e.kind), e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin err_cnt++; $display("FAIL midreset_event: got %s@%0d, expected %s@%0d", kname(o.kind), o.cyc, kname(e.kind), e.cyc); end
            end
        end
        vec_cnt++;
        if (obs_q.size() != 0) begin err_cnt++; $display("FAIL midreset_extra: got %0d extra events, expected 0", obs_q.size()); obs_q.delete(); end
        // Reset while the level is high must clear it before the next clock edge.
        #1 rst_n = 1'b0;
        btn = 1'b0;
        #1;
        vec_cnt++;
        if (btn_level !== 1'b0) begin err_cnt++; $display("FAIL async_reset_level: got %b, expected 0", btn_level); end
        step(2);
        rst_n = 1'b1;
        step(4);
        vec_cnt++;
        if (obs_q.size() != 0) begin err_cnt++; $display("FAIL async_reset_extra: got %0d events, expected 0", obs_q.size()); obs_q.delete(); end
        $display("reset_mid: done at cycle %0d, level=%b", cyc, btn_level);
    endtask

    task automatic test_long_press;
        int  c;
        ev_t e;
        ev_t o;
        c   = cyc;
        btn = 1'b1;
        exp_q.push_back(mk_ev(EV_RISE, c + LAT));
`ifdef BTN_DEBOUNCE_LONG_PRESS_EN
        exp_q.push_back(mk_ev(EV_LONG, c + LAT + LONG));
`endif
        step(60);
        c   = cyc;
        btn = 1'b0;
        exp_q.push_back(mk_ev(EV_FALL, c + LAT));
        step(12);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            vec_cnt++;
            if (obs_q.size() == 0) begin
                err_cnt++; $display("FAIL long_event: got none, expected %s@%0d", kname(e.kind), e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin err_cnt++; $display("FAIL long_event: got %s@%0d, expected %s@%0d", kname(o.kind), o.cyc, kname(e.kind), e.cyc); end
            end
        end
        vec_cnt++;
        if (obs_q.size() != 0) begin err_cnt++; $display("FAIL long_extra: got %0d extra events, expected 0", obs_q.size()); obs_q.delete(); end
        $display("long_press: done at cycle %0d, level=%b", cyc, btn_level);
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_release();
        test_bounce_reject();
        test_bounce_settle();
        test_reset_mid();
        test_long_press();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout at cycle %0d, expected completion", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
